// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: single-outstanding req/ack bus access with
// pipeline stall, load extension, misalign/illegal rejection and bus timeout.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        MemR_i,
  input  logic        MemW_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // state | meaning
  // IDLE  | decode a new access from EX/MEM
  // REQ   | bus request outstanding, waiting for ack or timeout
  // DONE  | access finished, rdata_o valid, pipeline released
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        acc, legal_f3, aligned, go, bad;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  assign acc = MemR_i | MemW_i;

  always_comb begin
    be_d     = 4'b1111;
    wd_d     = wdata_i;
    aligned  = 1'b1;
    case (funct3_i[1:0])
      2'b00: begin
        be_d = 4'b0001 << addr_i[1:0];
        wd_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wd_d    = {2{wdata_i[15:0]}};
        aligned = ~addr_i[0];
      end
      default: aligned = (addr_i[1:0] == 2'b00);
    endcase
    // MemW wins when both strobes are set, so legality follows the store table
    if (MemW_i)
      legal_f3 = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
    else
      legal_f3 = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b101);
  end

  assign go  = acc & legal_f3 & aligned;
  assign bad = acc & ~go;

  assign stall_o = rst_n & (((state == IDLE) & go) | (state == REQ));

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      rdata_o     <= 32'd0;
      misalign_o  <= 1'b0;
      buserr_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
    end else begin
      misalign_o <= 1'b0;
      buserr_o   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (go) begin
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_d;
            mem_wdata_o <= wd_d;
            mem_we_o    <= MemW_i;
            mem_req_o   <= 1'b1;
            off_q       <= addr_i[1:0];
            f3_q        <= funct3_i;
            state       <= REQ;
          end else if (bad) begin
            misalign_o <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (mem_ack_i) begin
            if (!mem_we_o) rdata_o <= ld_ext;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state     <= DONE;
          end else if (cnt == TO_LAST) begin
            if (!mem_we_o) rdata_o <= 32'd0;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            buserr_o  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan cases plus randomized
// accesses compared against a byte-lane arithmetic model of the access rules.
module tb_dmem_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        MemR_i, MemW_i, mem_ack_i;
  logic [2:0]  funct3_i;
  logic        stall_o, misalign_o, buserr_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rdata = 32'd0;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i),
    .MemR_i(MemR_i), .MemW_i(MemW_i), .funct3_i(funct3_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
    .buserr_o(buserr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_ok(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit legal;
    if (w) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else   legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (!legal) return 0;
    sz = acc_size(f3);
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'd0;
    int off = int'(a % 4);
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = 32'd0;
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    longint v;
    int sz = acc_size(f3);
    longint span = longint'(1) << (8 * sz);
    v = (longint'(word) >> (8 * (a % 4))) & (span - 1);
    if (f3 < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- access driver with inline checks ----------------
  task automatic run_access(input logic r, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int delay, input logic [31:0] rword);
    bit ok, acked;
    int stalls;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    ok  = model_ok(w, f3, a);
    ebe = model_be(f3, a);
    ewd = model_wd(f3, wd);
    @(negedge clk);
    MemR_i = r; MemW_i = w; funct3_i = f3; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    #1;
    if (!ok) begin
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL bad_stall: got %b want 0", stall_o); end
      @(negedge clk);
      n_cmp++; if (misalign_o !== 1'b1) begin n_bad++; $display("FAIL misalign_pulse: got %b want 1", misalign_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL bad_req: got %b want 0", mem_req_o); end
      MemR_i = 0; MemW_i = 0;
      @(negedge clk);
      n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL misalign_len: got %b want 0", misalign_o); end
      n_cmp++; if (rdata_o !== exp_rdata) begin n_bad++; $display("FAIL bad_rdata: got %h want %h", rdata_o, exp_rdata); end
      return;
    end
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL idle_stall: got %b want 1", stall_o); end
    stalls = 1;
    acked = 0;
    for (int k = 0; k < TO && !acked; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL req k=%0d: got %b want 1", k, mem_req_o); end
      n_cmp++; if (mem_we_o !== w) begin n_bad++; $display("FAIL we: got %b want %b", mem_we_o, w); end
      n_cmp++; if (mem_addr_o !== {a[31:2], 2'b00}) begin n_bad++; $display("FAIL addr: got %h want %h", mem_addr_o, {a[31:2], 2'b00}); end
      n_cmp++; if (mem_be_o !== ebe) begin n_bad++; $display("FAIL be: got %b want %b", mem_be_o, ebe); end
      if (w) begin
        n_cmp++; if (mem_wdata_o !== ewd) begin n_bad++; $display("FAIL wdata: got %h want %h", mem_wdata_o, ewd); end
      end
      if (stall_o === 1'b1) stalls++;
      acked = (k == delay);
      mem_ack_i = acked;
      mem_rdata_i = acked ? rword : $urandom;
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;
    if (!w) exp_rdata = acked ? model_load(f3, a, rword) : 32'd0;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL done_stall: got %b want 0", stall_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL done_req: got %b want 0", mem_req_o); end
    n_cmp++; if (buserr_o !== !acked) begin n_bad++; $display("FAIL buserr: got %b want %b", buserr_o, !acked); end
    n_cmp++; if (rdata_o !== exp_rdata) begin n_bad++; $display("FAIL rdata: got %h want %h", rdata_o, exp_rdata); end
    n_cmp++; if (stalls !== (acked ? delay + 2 : TO + 1)) begin n_bad++; $display("FAIL stall_len: got %0d want %0d", stalls, acked ? delay + 2 : TO + 1); end
    MemR_i = 0; MemW_i = 0;
    @(negedge clk);
    n_cmp++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || buserr_o !== 1'b0) begin
      n_bad++; $display("FAIL post_idle: got req=%b stall=%b buserr=%b want 000", mem_req_o, stall_o, buserr_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; MemR_i = 0; MemW_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({stall_o, misalign_o, buserr_o, mem_req_o, mem_we_o} !== 5'd0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 00000", {stall_o, misalign_o, buserr_o, mem_req_o, mem_we_o});
    end
    n_cmp++; if ({rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'd0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h %b want 0", rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    n_cmp++; if (rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_const: got %h want deadbeef", rdata_o); end
  endtask

  task automatic test_subword();
    run_access(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80112233);
    n_cmp++; if (rdata_o !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_const: got %h want ffffff80", rdata_o); end
    run_access(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233);
    n_cmp++; if (rdata_o !== 32'h00000080) begin n_bad++; $display("FAIL lbu_const: got %h want 00000080", rdata_o); end
    run_access(1, 0, 3'b001, 32'h202, 32'h0, 2, 32'h80112233);
    n_cmp++; if (rdata_o !== 32'hFFFF8011) begin n_bad++; $display("FAIL lh_const: got %h want ffff8011", rdata_o); end
  endtask

  task automatic test_store();
    run_access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'h0);
    n_cmp++; if (rdata_o !== 32'hFFFF8011) begin n_bad++; $display("FAIL sh_rdata_kept: got %h want ffff8011", rdata_o); end
    run_access(1, 1, 3'b000, 32'h305, 32'h000000A5, 3, 32'h0);
  endtask

  task automatic test_misalign();
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    run_access(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_access(0, 1, 3'b010, 32'h500, 32'hCAFEF00D, 3, 32'h0);
    run_access(0, 1, 3'b010, 32'h504, 32'h11111111, 1000, 32'h0);
    run_access(1, 0, 3'b010, 32'h508, 32'h0, TO - 1, 32'h13572468);
    run_access(1, 0, 3'b101, 32'h50A, 32'h0, 1000, 32'h0);
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    MemR_i = 1; MemW_i = 0; funct3_i = 3'b010; addr_i = 32'h400;
    repeat (2) @(negedge clk);
    rst_n = 0; MemR_i = 0;
    #1;
    exp_rdata = 32'd0;
    n_cmp++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_in_req: got req=%b stall=%b want 00", mem_req_o, stall_o);
    end
    n_cmp++; if (rdata_o !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_ack_i = 1; mem_rdata_i = 32'h89ABCDEF;
    @(negedge clk);
    mem_ack_i = 0;
    n_cmp++; if (rdata_o !== 32'd0 || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL late_ack: got rdata=%h req=%b want 0 0", rdata_o, mem_req_o);
    end
    run_access(1, 0, 3'b010, 32'h400, 32'h0, 1, 32'h24681357);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic r, w;
      logic [2:0] f3;
      logic [31:0] a;
      int sel = $urandom_range(0, 3);
      r = (sel != 1);
      w = (sel == 1) || (sel == 3 && $urandom_range(0, 1) == 1);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'({$urandom_range(0, 1), 2'($urandom_range(0, 2))});
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_access(r, w, f3, a, $urandom, $urandom_range(0, 5), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1, 0, 3'b000, 32'h600, 32'h0, 0, 32'h0000007F);
    run_access(0, 1, 3'b000, 32'h601, 32'h000000EE, 0, 32'h0);
    run_access(1, 0, 3'b001, 32'h602, 32'h0, 0, 32'h7FFF0000);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_subword();
    test_store();
    test_misalign();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_in_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
